// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: op encoding, access sizes, FSM states.
// Pure declarations, no logic.
// Imported by mem_stage, mem_align and the bench.
package mem_stage_pkg;

   typedef enum logic [3:0] {
      OP_NONE = 4'd0,
      OP_LB   = 4'd1,
      OP_LBU  = 4'd2,
      OP_LH   = 4'd3,
      OP_LHU  = 4'd4,
      OP_LW   = 4'd5,
      OP_SB   = 4'd6,
      OP_SH   = 4'd7,
      OP_SW   = 4'd8
   } mem_op_t;

   localparam logic [1:0] MSIZE_BYTE = 2'd0;
   localparam logic [1:0] MSIZE_HALF = 2'd1;
   localparam logic [1:0] MSIZE_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } mem_state_t;

endpackage

// File: rtl/mem_stage_align.sv
// Access decode: bus size/strobe/lane data, misalignment, load extract + extend.
// Purely combinational, zero latency.
// No flow control; the caller decides when outputs are meaningful.
module mem_align
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  mem_op_t           i_op,
   input  logic [1:0]        i_addr_lo,
   input  logic [ADDR_W-1:0] i_vt,
   input  logic [ADDR_W-1:0] i_raw,
   output logic [1:0]        o_size,
   output logic [3:0]        o_strobe,
   output logic [ADDR_W-1:0] o_data,
   output logic              o_misalign,
   output logic              o_is_load,
   output logic              o_is_store,
   output logic [ADDR_W-1:0] o_load_val
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // raw word is always read from the aligned address, so lanes are picked by the low bits
   assign w_byte = i_raw[{i_addr_lo, 3'b000} +: 8];
   assign w_half = i_addr_lo[1] ? i_raw[31:16] : i_raw[15:0];

   // decode the op into bus controls and the extended load value
   always_comb begin
      o_size     = MSIZE_BYTE;
      o_strobe   = 4'b0000;
      o_data     = '0;
      o_misalign = 1'b0;
      o_is_load  = 1'b0;
      o_is_store = 1'b0;
      o_load_val = '0;
      case (i_op)
         OP_LB: begin
            o_is_load  = 1'b1;
            o_load_val = {{24{w_byte[7]}}, w_byte};
         end
         OP_LBU: begin
            o_is_load  = 1'b1;
            o_load_val = {24'd0, w_byte};
         end
         OP_LH: begin
            o_is_load  = 1'b1;
            o_size     = MSIZE_HALF;
            o_misalign = i_addr_lo[0];
            o_load_val = {{16{w_half[15]}}, w_half};
         end
         OP_LHU: begin
            o_is_load  = 1'b1;
            o_size     = MSIZE_HALF;
            o_misalign = i_addr_lo[0];
            o_load_val = {16'd0, w_half};
         end
         OP_LW: begin
            o_is_load  = 1'b1;
            o_size     = MSIZE_WORD;
            o_misalign = |i_addr_lo;
            o_load_val = i_raw;
         end
         OP_SB: begin
            o_is_store = 1'b1;
            o_data     = {4{i_vt[7:0]}};
            o_strobe   = 4'b0001 << i_addr_lo;
         end
         OP_SH: begin
            o_is_store = 1'b1;
            o_size     = MSIZE_HALF;
            o_misalign = i_addr_lo[0];
            o_data     = {2{i_vt[15:0]}};
            o_strobe   = i_addr_lo[1] ? 4'b1100 : 4'b0011;
         end
         OP_SW: begin
            o_is_store = 1'b1;
            o_size     = MSIZE_WORD;
            o_misalign = |i_addr_lo;
            o_data     = i_vt;
            o_strobe   = 4'b1111;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: runs one data-bus transaction per load/store, emits a write-back record.
// Latency: non-memory op 1 cycle; memory op >= 2 cycles (request at t+1, record at t+2 on a zero-wait bus).
// Backpressure: in_ready drops while busy or while a record waits for out_ready.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [ADDR_W-1:0] in_result,
   input  logic [ADDR_W-1:0] in_vt,
   input  logic [4:0]        in_rd,
   output logic              dreq_valid,
   output logic [ADDR_W-1:0] dreq_addr,
   output logic [1:0]        dreq_size,
   output logic [3:0]        dreq_strobe,
   output logic [ADDR_W-1:0] dreq_data,
   input  logic              dresp_addr_ok,
   input  logic              dresp_data_ok,
   input  logic [ADDR_W-1:0] dresp_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [4:0]        out_rd,
   output logic [ADDR_W-1:0] out_value,
   output logic              out_we,
   output logic              out_adel,
   output logic              out_ades
);

   mem_state_t        r_state;
   mem_state_t        w_state_nxt;
   mem_op_t           r_op;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_vt;
   logic [4:0]        r_rd;
   logic [ADDR_W-1:0] r_value;
   logic              r_we;
   logic              r_adel;
   logic              r_ades;

   logic              w_sel_in;
   mem_op_t           w_op;
   logic [1:0]        w_addr_lo;
   logic [1:0]        w_size;
   logic [3:0]        w_strobe;
   logic [ADDR_W-1:0] w_data;
   logic              w_misalign;
   logic              w_is_load;
   logic              w_is_store;
   logic [ADDR_W-1:0] w_load_val;
   mem_state_t        w_branch;
   logic              w_accept;
   logic              w_capture;

   // Decoder sees the incoming op while we can accept, the latched op while a transaction is open.
   assign w_sel_in  = (r_state == ST_IDLE) || (r_state == ST_DONE);
   assign w_op      = w_sel_in ? mem_op_t'(in_op) : r_op;
   assign w_addr_lo = w_sel_in ? in_result[1:0] : r_addr[1:0];

   mem_align #(.ADDR_W(ADDR_W)) u_align (
      .i_op       (w_op),
      .i_addr_lo  (w_addr_lo),
      .i_vt       (r_vt),
      .i_raw      (dresp_data),
      .o_size     (w_size),
      .o_strobe   (w_strobe),
      .o_data     (w_data),
      .o_misalign (w_misalign),
      .o_is_load  (w_is_load),
      .o_is_store (w_is_store),
      .o_load_val (w_load_val)
   );

   // misaligned accesses skip the bus and report straight away
   assign w_branch = ((w_op == OP_NONE) || w_misalign) ? ST_DONE : ST_ADDR;

   // state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // next state, handshakes and capture strobe
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      in_ready    = 1'b0;
      dreq_valid  = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = w_branch;
            end
         end
         ST_ADDR: begin
            dreq_valid = 1'b1;
            if (dresp_addr_ok && dresp_data_ok) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_DONE;
            end else if (dresp_addr_ok) begin
               w_state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (dresp_data_ok) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) begin
               if (in_valid) begin
                  w_accept    = 1'b1;
                  w_state_nxt = w_branch;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // latch the instruction on accept, overwrite the value with load data on completion
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_op    <= OP_NONE;
         r_addr  <= '0;
         r_vt    <= '0;
         r_rd    <= '0;
         r_value <= '0;
         r_we    <= 1'b0;
         r_adel  <= 1'b0;
         r_ades  <= 1'b0;
      end else if (w_accept) begin
         r_op    <= w_op;
         r_addr  <= in_result;
         r_vt    <= in_vt;
         r_rd    <= in_rd;
         r_value <= in_result;
         r_we    <= (in_rd != 5'd0) && !w_misalign && !w_is_store;
         r_adel  <= w_misalign && w_is_load;
         r_ades  <= w_misalign && w_is_store;
      end else if (w_capture) begin
         r_value <= w_load_val;
      end
   end

   // request fields are driven only while the request is open
   assign dreq_addr   = dreq_valid ? r_addr   : '0;
   assign dreq_size   = dreq_valid ? w_size   : 2'd0;
   assign dreq_strobe = dreq_valid ? w_strobe : 4'd0;
   assign dreq_data   = dreq_valid ? w_data   : '0;

   assign out_rd    = r_rd;
   assign out_value = r_value;
   assign out_we    = r_we;
   assign out_adel  = r_adel;
   assign out_ades  = r_ades;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with hand-computed expectations.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [31:0] in_result;
   logic [31:0] in_vt;
   logic [4:0]  in_rd;
   logic        dreq_valid;
   logic [31:0] dreq_addr;
   logic [1:0]  dreq_size;
   logic [3:0]  dreq_strobe;
   logic [31:0] dreq_data;
   logic        dresp_addr_ok;
   logic        dresp_data_ok;
   logic [31:0] dresp_data;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_rd;
   logic [31:0] out_value;
   logic        out_we;
   logic        out_adel;
   logic        out_ades;

   int n_checks = 0;
   int n_fail   = 0;
   int dreq_cnt = 0;
   int cnt0;

   mem_stage #(.ADDR_W(32)) dut (
      .clk(clk), .resetn(resetn),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_result(in_result), .in_vt(in_vt), .in_rd(in_rd),
      .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
      .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
      .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
      .out_value(out_value), .out_we(out_we), .out_adel(out_adel), .out_ades(out_ades)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (dreq_valid === 1'b1) dreq_cnt = dreq_cnt + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (obs !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%08h required 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] res, input logic [31:0] vt,
                        input logic [4:0] rd);
      in_valid  = 1'b1;
      in_op     = op;
      in_result = res;
      in_vt     = vt;
      in_rd     = rd;
   endtask

   task automatic bus(input logic a, input logic d, input logic [31:0] data);
      dresp_addr_ok = a;
      dresp_data_ok = d;
      dresp_data    = data;
   endtask

   initial begin
      resetn = 1'b0;
      in_valid = 1'b0; in_op = '0; in_result = '0; in_vt = '0; in_rd = '0;
      out_ready = 1'b0;
      bus(1'b0, 1'b0, 32'd0);
      repeat (2) @(negedge clk);
      chk("rst_in_ready",   32'(in_ready),   32'd1);
      chk("rst_out_valid",  32'(out_valid),  32'd0);
      chk("rst_dreq_valid", 32'(dreq_valid), 32'd0);
      chk("rst_out_value",  out_value,       32'd0);
      chk("rst_out_we",     32'(out_we),     32'd0);
      chk("rst_dreq_addr",  dreq_addr,       32'd0);
      resetn = 1'b1;
      @(negedge clk);

      // NONE op: record one cycle after acceptance, no bus traffic
      out_ready = 1'b1;
      cnt0 = dreq_cnt;
      drive(OP_NONE, 32'h0000_1234, 32'd0, 5'd5);
      @(negedge clk); in_valid = 1'b0;
      chk("none_valid", 32'(out_valid), 32'd1);
      chk("none_value", out_value,      32'h0000_1234);
      chk("none_we",    32'(out_we),    32'd1);
      chk("none_rd",    32'(out_rd),    32'd5);
      @(negedge clk);
      chk("none_idle",  32'(out_valid), 32'd0);
      chk("none_nobus", 32'(dreq_cnt - cnt0), 32'd0);

      // LB / LBU with zero-wait bus
      bus(1'b1, 1'b1, 32'h80FF_FF7F);
      drive(OP_LB, 32'h0000_0103, 32'd0, 5'd9);
      @(negedge clk); in_valid = 1'b0;
      chk("lb_dreq_valid",  32'(dreq_valid),  32'd1);
      chk("lb_dreq_addr",   dreq_addr,        32'h0000_0103);
      chk("lb_dreq_size",   32'(dreq_size),   32'd0);
      chk("lb_dreq_strobe", 32'(dreq_strobe), 32'd0);
      chk("lb_not_yet",     32'(out_valid),   32'd0);
      @(negedge clk);
      chk("lb_valid", 32'(out_valid), 32'd1);
      chk("lb_value", out_value,      32'hFFFF_FF80);
      chk("lb_we",    32'(out_we),    32'd1);
      drive(OP_LBU, 32'h0000_0103, 32'd0, 5'd9);
      @(negedge clk); in_valid = 1'b0;
      chk("lbu_dreq_valid", 32'(dreq_valid), 32'd1);
      @(negedge clk);
      chk("lbu_valid", 32'(out_valid), 32'd1);
      chk("lbu_value", out_value,      32'h0000_0080);
      bus(1'b0, 1'b0, 32'd0);
      @(negedge clk);

      // SH with slow bus: request fields stable while waiting
      drive(OP_SH, 32'h0000_0202, 32'hDEAD_BEEF, 5'd6);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); in_valid = 1'b0;
         chk("sh_dreq_valid",  32'(dreq_valid),  32'd1);
         chk("sh_dreq_addr",   dreq_addr,        32'h0000_0202);
         chk("sh_dreq_data",   dreq_data,        32'hBEEF_BEEF);
         chk("sh_dreq_strobe", 32'(dreq_strobe), 32'hC);
         chk("sh_dreq_size",   32'(dreq_size),   32'd1);
      end
      bus(1'b1, 1'b0, 32'd0);
      @(negedge clk); bus(1'b0, 1'b0, 32'd0);
      chk("sh_data_wait_req", 32'(dreq_valid), 32'd0);
      chk("sh_data_wait_out", 32'(out_valid),  32'd0);
      @(negedge clk); bus(1'b0, 1'b1, 32'd0);
      @(negedge clk); bus(1'b0, 1'b0, 32'd0);
      chk("sh_valid", 32'(out_valid), 32'd1);
      chk("sh_we",    32'(out_we),    32'd0);
      chk("sh_ades",  32'(out_ades),  32'd0);
      @(negedge clk);

      // misaligned LW then SW: no bus, address error reported
      cnt0 = dreq_cnt;
      drive(OP_LW, 32'h0000_0106, 32'd0, 5'd8);
      @(negedge clk);
      chk("lw_mis_valid", 32'(out_valid),  32'd1);
      chk("lw_mis_adel",  32'(out_adel),   32'd1);
      chk("lw_mis_ades",  32'(out_ades),   32'd0);
      chk("lw_mis_value", out_value,       32'h0000_0106);
      chk("lw_mis_we",    32'(out_we),     32'd0);
      chk("lw_mis_req",   32'(dreq_valid), 32'd0);
      drive(OP_SW, 32'h0000_0101, 32'h0000_0055, 5'd0);
      @(negedge clk); in_valid = 1'b0;
      chk("sw_mis_ades",  32'(out_ades), 32'd1);
      chk("sw_mis_adel",  32'(out_adel), 32'd0);
      chk("sw_mis_value", out_value,     32'h0000_0101);
      chk("sw_mis_we",    32'(out_we),   32'd0);
      @(negedge clk);
      chk("mis_nobus", 32'(dreq_cnt - cnt0), 32'd0);

      // LW then NONE with writeback stalled
      out_ready = 1'b0;
      bus(1'b1, 1'b1, 32'h1234_5678);
      drive(OP_LW, 32'h0000_0100, 32'd0, 5'd7);
      @(negedge clk);
      drive(OP_NONE, 32'h0000_0ABC, 32'd0, 5'd3);
      chk("b2b_busy_ready", 32'(in_ready), 32'd0);
      @(negedge clk); bus(1'b0, 1'b0, 32'd0);
      chk("b2b_lw_rd", 32'(out_rd), 32'd7);
      chk("b2b_lw_we", 32'(out_we), 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("b2b_hold_valid", 32'(out_valid), 32'd1);
         chk("b2b_hold_value", out_value,      32'h1234_5678);
         chk("b2b_hold_ready", 32'(in_ready),  32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      chk("b2b_release_ready", 32'(in_ready), 32'd1);
      @(negedge clk); in_valid = 1'b0;
      chk("b2b_none_valid", 32'(out_valid), 32'd1);
      chk("b2b_none_value", out_value,      32'h0000_0ABC);
      chk("b2b_none_rd",    32'(out_rd),    32'd3);
      @(negedge clk);
      chk("b2b_idle", 32'(out_valid), 32'd0);

      // reset while waiting for load data
      drive(OP_LW, 32'h0000_0200, 32'd0, 5'd4);
      bus(1'b1, 1'b0, 32'd0);
      @(negedge clk); in_valid = 1'b0;
      chk("rstd_addr_req", 32'(dreq_valid), 32'd1);
      @(negedge clk); bus(1'b0, 1'b0, 32'd0);
      chk("rstd_in_data", 32'(dreq_valid), 32'd0);
      chk("rstd_pre_val", out_value,       32'h0000_0200);
      resetn = 1'b0;
      #1;
      chk("rstd_value",    out_value,      32'd0);
      chk("rstd_in_ready", 32'(in_ready),  32'd1);
      chk("rstd_rd",       32'(out_rd),    32'd0);
      chk("rstd_valid",    32'(out_valid), 32'd0);
      @(negedge clk); resetn = 1'b1;
      @(negedge clk);
      bus(1'b1, 1'b1, 32'h0000_8001);
      drive(OP_LHU, 32'h0000_0000, 32'd0, 5'd2);
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk);
      chk("lhu_valid", 32'(out_valid), 32'd1);
      chk("lhu_value", out_value,      32'h0000_8001);
      bus(1'b0, 1'b0, 32'd0);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
